// File: rtl/orient_hist32_if.sv
// orient_hist32_if: sample/result handshake bundle for the orientation histogram.
interface orient_hist32_if #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
);
    logic             start;
    logic             in_valid;
    logic [4:0]       in_dir;
    logic [MAG_W-1:0] in_mag;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_dir;
    logic [ACC_W-1:0] out_peak;
    logic             busy;
    modport slave (
        input  start, in_valid, in_dir, in_mag, in_last, out_ready,
        output in_ready, out_valid, out_dir, out_peak, busy
    );
    modport master (
        output start, in_valid, in_dir, in_mag, in_last, out_ready,
        input  in_ready, out_valid, out_dir, out_peak, busy
    );
endinterface

// File: rtl/orient_hist32.sv
// orient_hist32: 32-bin orientation histogram with dominant-bin scan.
// Define ORIENT_HIST_SMOOTH_EN to rank bins by circular [1 2 1]/4 smoothed values.
module orient_hist32 #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input logic            clk,
    input logic            rst_n,
    orient_hist32_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SCAN, DONE} state_t;
    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       dir_q, dir_d;
    logic [ACC_W-1:0] peak_q, peak_d;
    logic [ACC_W-1:0] bins_q [32];
    logic             accept;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] cand;
    assign accept = state_q == ACCUM && bus.in_valid;
    assign sum = {1'b0, bins_q[bus.in_dir]} + (ACC_W+1)'(bus.in_mag);
`ifdef ORIENT_HIST_SMOOTH_EN
    logic [4:0]       prv, nxt;
    logic [ACC_W+1:0] sm;
    assign prv = cnt_q - 5'd1;
    assign nxt = cnt_q + 5'd1;
    assign sm = (ACC_W+2)'(bins_q[prv]) + (ACC_W+2)'({bins_q[cnt_q], 1'b0}) + (ACC_W+2)'(bins_q[nxt]);
    assign cand = ACC_W'(sm >> 2);
`else
    assign cand = bins_q[cnt_q];
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        peak_d = peak_q;
        case (state_q)
            IDLE: begin
                state_d = bus.start ? CLEAR : IDLE;
                cnt_d = '0;
            end
            CLEAR: begin
                cnt_d = cnt_q + 5'd1;
                state_d = cnt_q == 5'd31 ? ACCUM : CLEAR;
            end
            ACCUM: state_d = accept && bus.in_last ? SCAN : ACCUM;
            SCAN: begin
                cnt_d = cnt_q + 5'd1;
                state_d = cnt_q == 5'd31 ? DONE : SCAN;
                // first bin seeds the max so ties resolve to the lowest index
                if (cnt_q == 5'd0 || cand > peak_q) begin
                    dir_d = cnt_q;
                    peak_d = cand;
                end
            end
            DONE: begin
                state_d = bus.start ? CLEAR : bus.out_ready ? IDLE : DONE;
                cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            dir_q <= '0;
            peak_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            peak_q <= peak_d;
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            bins_q[cnt_q] <= '0;
        else if (accept)
            bins_q[bus.in_dir] <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end
    assign bus.in_ready = state_q == ACCUM;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy = state_q != IDLE;
    assign bus.out_dir = dir_q;
    assign bus.out_peak = peak_q;
endmodule

// File: tb/tb_orient_hist32.sv
// tb_orient_hist32: randomized scoreboard bench against a histogram/argmax model.
module tb_orient_hist32;
    localparam int MAG_W = 8;
    localparam int ACC_W = 16;
    localparam int MAXV = (1 << ACC_W) - 1;
    logic clk = 0;
    logic rst_n = 0;
    orient_hist32_if #(.MAG_W(MAG_W), .ACC_W(ACC_W)) bus ();
    orient_hist32 #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    int n_chk = 0, n_pass = 0, n_res = 0, n_exp = 0;
    int hist [32];
    int exp_dir [$];
    int exp_peak [$];
    int last_dir, last_peak;
    task automatic chk(string name, int act, int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    endtask
    task automatic model_push();
        int best_d = 0, best_v = -1, v;
        for (int i = 0; i < 32; i++) begin
`ifdef ORIENT_HIST_SMOOTH_EN
            v = (hist[(i + 31) % 32] + 2 * hist[i] + hist[(i + 1) % 32]) / 4;
`else
            v = hist[i];
`endif
            if (v > best_v) begin best_v = v; best_d = i; end
        end
        exp_dir.push_back(best_d);
        exp_peak.push_back(best_v);
        last_dir = best_d;
        last_peak = best_v;
        n_exp++;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start();
        for (int i = 0; i < 32; i++) hist[i] = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask
    task automatic wait_ready();
        for (int k = 0; k < 100 && !bus.in_ready; k++) tick();
        chk("accum_entry", int'(bus.in_ready), 1);
    endtask
    task automatic send(int d, int m, bit last);
        chk("in_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1;
        bus.in_dir = 5'(d);
        bus.in_mag = MAG_W'(m);
        bus.in_last = last;
        hist[d] = (hist[d] + m > MAXV) ? MAXV : hist[d] + m;
        tick();
        bus.in_valid = 0;
        bus.in_last = 0;
    endtask
    task automatic get_result(int hold, bit watch);
        for (int k = 0; k < 100 && !bus.out_valid; k++) tick();
        if (!bus.out_valid) begin
            chk("done_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < hold; k++) begin
            if (watch) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_dir", int'(bus.out_dir), last_dir);
                chk("hold_peak", int'(bus.out_peak), last_peak);
            end
            tick();
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("idle_after_ack", int'(bus.busy), 0);
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_dir.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                chk("out_dir", int'(bus.out_dir), exp_dir.pop_front());
                chk("out_peak", int'(bus.out_peak), exp_peak.pop_front());
                n_res++;
            end
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        int k;
        bus.start = 0; bus.in_valid = 0; bus.in_dir = 0; bus.in_mag = 0;
        bus.in_last = 0; bus.out_ready = 0;
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_dir", int'(bus.out_dir), 0);
        chk("rst_out_peak", int'(bus.out_peak), 0);
        rst_n = 1;
        tick();
        // directed windows
        do_start(); wait_ready();
        send(5, 10, 0); send(5, 20, 0); send(9, 25, 1);
        model_push(); get_result(0, 0);
        do_start(); wait_ready();
        send(3, 40, 0); send(17, 40, 1);
        model_push(); get_result(10, 1);
        do_start(); wait_ready();
        for (int i = 0; i < 300; i++) send(31, 255, i == 299);
        model_push(); get_result(2, 0);
        do_start(); wait_ready();
        send(0, 100, 0); send(31, 100, 0); send(1, 60, 1);
        model_push(); get_result(1, 0);
        // reset in the middle of a window
        do_start(); wait_ready();
        send(4, 200, 0); send(4, 200, 0);
        rst_n = 0; tick(); rst_n = 1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 0);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        do_start(); wait_ready();
        send(7, 1, 1);
        model_push(); get_result(0, 0);
        // start/in_valid while clearing, start during ACCUM and SCAN
        do_start();
        k = 1;
        while (!bus.in_ready && k < 100) begin
            bus.start = (k == 5);
            bus.in_valid = (k >= 3 && k <= 10);
            bus.in_dir = 5'd2;
            bus.in_mag = 8'd50;
            if (k == 10) chk("clear_in_ready", int'(bus.in_ready), 0);
            tick();
            k++;
        end
        bus.start = 0; bus.in_valid = 0;
        chk("clear_len", k, 33);
        bus.start = 1; send(2, 7, 0); bus.start = 0;
        send(4, 9, 1);
        bus.start = 1; tick(); bus.start = 0;
        model_push(); get_result(0, 0);
        // randomized windows
        for (int w = 0; w < 8; w++) begin
            int n;
            do_start(); wait_ready();
            n = $urandom_range(1, 40);
            for (int j = 0; j < n; j++) begin
                int d;
                if ($urandom % 4 == 0) tick();
                d = ($urandom % 3 == 0) ? int'($urandom % 32) : int'($urandom % 4) * 8;
                send(d, int'($urandom % 256), j == n - 1);
            end
            model_push();
            get_result(int'($urandom_range(0, 3)), 0);
        end
        repeat (5) tick();
        chk("scoreboard_empty", exp_dir.size(), 0);
        chk("result_count", n_res, n_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
